// File: rtl/fir_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_filter_pkg
// Description : Shared widths, defaults and checker state encoding for the
//               FIR response checker and its expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_filter_pkg;

  localparam int unsigned C_DATA_WIDTH     = 16;
  localparam int unsigned C_NUM_TAPS       = 8;
  // Full-precision FIR output: product width plus tap-accumulation growth.
  localparam int unsigned C_OUTPUT_WIDTH   = 2 * C_DATA_WIDTH + $clog2(C_NUM_TAPS);
  localparam int unsigned C_FIFO_DEPTH     = 8;
  localparam int unsigned C_NUM_VECTORS    = 64;
  localparam int unsigned C_TIMEOUT_CYCLES = 256;
  localparam int unsigned C_COUNT_WIDTH    = 16;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_RUN   = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;
  localparam logic [1:0] C_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_RUN   = C_ST_RUN,
    ST_DRAIN = C_ST_DRAIN,
    ST_DONE  = C_ST_DONE
  } chk_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [C_COUNT_WIDTH-1:0] sat_inc(input logic [C_COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + C_COUNT_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_check_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_check_fifo
// Description : Synchronous expected-value queue with registered full/empty
//               flags and an occupancy output. DEPTH must be a power of two
//               (>= 2) so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_check_fifo
  import fir_filter_pkg::*;
#(
  parameter int unsigned WIDTH = C_OUTPUT_WIDTH,
  parameter int unsigned DEPTH = C_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned C_AW = $clog2(DEPTH);
  localparam int unsigned C_CW = C_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_CW-1:0]  r_count;
  logic [C_CW-1:0]  w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full queue or a pop from an empty one is silently ignored.
  assign w_do_push = push && !r_full;
  assign w_do_pop  = pop && !r_empty;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + C_CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_next = r_count - C_CW'(1);
    end
  end

  // Pointers, occupancy and flags; flags are registered from next occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fir_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : fir_response_checker
// Description : Queues expected FIR outputs, compares each received output
//               strobe against the queue head and reports errors, counts,
//               completion, pass and drain timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_response_checker
  import fir_filter_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH   = C_OUTPUT_WIDTH,
  parameter int unsigned FIFO_DEPTH     = C_FIFO_DEPTH,
  parameter int unsigned NUM_VECTORS    = C_NUM_VECTORS,
  parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      exp_valid,
  input  logic [OUTPUT_WIDTH-1:0]   exp_data,
  output logic                      exp_ready,
  input  logic                      output_valid,
  input  logic [OUTPUT_WIDTH-1:0]   y,
  output logic                      error,
  output logic [C_COUNT_WIDTH-1:0]  error_count,
  output logic [C_COUNT_WIDTH-1:0]  checked_count,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout
);

  localparam int unsigned C_PCW = $clog2(NUM_VECTORS + 1);
  localparam int unsigned C_ICW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned C_QCW = $clog2(FIFO_DEPTH) + 1;

  chk_state_t               r_state;
  chk_state_t               w_state_next;
  logic [C_PCW-1:0]         r_push_count;
  logic [C_ICW-1:0]         r_idle_count;
  logic [C_COUNT_WIDTH-1:0] r_error_count;
  logic [C_COUNT_WIDTH-1:0] r_checked_count;
  logic                     r_error;
  logic                     r_done;
  logic                     r_pass;
  logic                     r_timeout;

  logic                     w_accepting;
  logic                     w_active;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last_push;
  logic                     w_mismatch;
  logic                     w_timeout_hit;
  logic [OUTPUT_WIDTH-1:0]  w_head;
  logic                     w_q_full;
  logic                     w_q_empty;
  // Occupancy is exposed by the queue for debug; the checker only needs the flags.
  logic [C_QCW-1:0]         w_q_count_unused;

  // Pushes are only taken before the run's vector budget is exhausted.
  assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign exp_ready   = w_accepting && !w_q_full;
  assign w_push      = exp_valid && exp_ready;
  assign w_last_push = w_push && (r_push_count == C_PCW'(NUM_VECTORS - 1));
  // No push-to-pop bypass: an empty queue underflows even if a push lands now.
  assign w_pop       = output_valid && w_active && !w_q_empty;
  assign w_mismatch  = output_valid && (!w_active || w_q_empty || (y != w_head));

  fir_check_fifo #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .wdata  (exp_data),
    .pop    (w_pop),
    .rdata  (w_head),
    .full   (w_q_full),
    .empty  (w_q_empty),
    .count  (w_q_count_unused)
  );

  // Next-state logic: push budget drives RUN->DRAIN, completion or idle timeout ends DRAIN.
  always_comb begin
    w_state_next  = r_state;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_next = w_last_push ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (w_last_push) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_checked_count >= C_COUNT_WIDTH'(NUM_VECTORS)) begin
          w_state_next = ST_DONE;
        end else if (r_idle_count >= C_ICW'(TIMEOUT_CYCLES)) begin
          w_state_next  = ST_DONE;
          w_timeout_hit = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Push budget and DRAIN idle counter (held at zero outside DRAIN and on every strobe).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_push_count <= '0;
      r_idle_count <= '0;
    end else begin
      if (w_push) r_push_count <= r_push_count + C_PCW'(1);
      if ((r_state != ST_DRAIN) || output_valid) begin
        r_idle_count <= '0;
      end else if (r_idle_count != C_ICW'(TIMEOUT_CYCLES)) begin
        r_idle_count <= r_idle_count + C_ICW'(1);
      end
    end
  end

  // Result reporting: error pulse, saturating totals and sticky completion flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_error         <= 1'b0;
      r_error_count   <= '0;
      r_checked_count <= '0;
      r_done          <= 1'b0;
      r_timeout       <= 1'b0;
      r_pass          <= 1'b0;
    end else begin
      r_error <= w_mismatch;
      if (w_mismatch) r_error_count <= sat_inc(r_error_count);
      if (output_valid && w_active) r_checked_count <= sat_inc(r_checked_count);
      if (w_state_next == ST_DONE) r_done <= 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
      r_pass <= r_done && (r_error_count == '0) && !r_timeout;
    end
  end

  assign error         = r_error;
  assign error_count   = r_error_count;
  assign checked_count = r_checked_count;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fir_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_response_checker
// Description : Self-checking bench for fir_response_checker. A queue-based
//               reference model predicts error pulses, counts and pass/done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_response_checker;

  localparam int W = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  // Main instance: 4 vectors per run, depth 8.
  logic          exp_valid, exp_ready, output_valid, error, done, pass, timeout;
  logic [W-1:0]  exp_data, y;
  logic [15:0]   error_count, checked_count;
  // Second instance: depth 4, 8 vectors, used for the full-queue scenario.
  logic          exp_valid_f, exp_ready_f, output_valid_f, error_f, done_f, pass_f, timeout_f;
  logic [W-1:0]  exp_data_f, y_f;
  logic [15:0]   error_count_f, checked_count_f;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of outstanding expectations and predicted error total.
  logic [W-1:0] model_q [$];
  int           model_errs;

  fir_response_checker #(.NUM_VECTORS(4)) u_dut (
    .clk(clk), .resetn(resetn), .exp_valid(exp_valid), .exp_data(exp_data),
    .exp_ready(exp_ready), .output_valid(output_valid), .y(y), .error(error),
    .error_count(error_count), .checked_count(checked_count), .done(done),
    .pass(pass), .timeout(timeout)
  );

  fir_response_checker #(.FIFO_DEPTH(4), .NUM_VECTORS(8)) u_dut_f (
    .clk(clk), .resetn(resetn), .exp_valid(exp_valid_f), .exp_data(exp_data_f),
    .exp_ready(exp_ready_f), .output_valid(output_valid_f), .y(y_f), .error(error_f),
    .error_count(error_count_f), .checked_count(checked_count_f), .done(done_f),
    .pass(pass_f), .timeout(timeout_f)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_val();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] corrupt(input logic [W-1:0] v);
    logic [W-1:0] m;
    m = '0;
    m[$urandom_range(W-1, 0)] = 1'b1;
    return v ^ m;
  endfunction

  task automatic apply_reset();
    exp_valid = 0; exp_data = '0; output_valid = 0; y = '0;
    exp_valid_f = 0; exp_data_f = '0; output_valid_f = 0; y_f = '0;
    resetn = 0;
    step(); step();
    resetn = 1;
    step();
    model_q.delete();
    model_errs = 0;
  endtask

  task automatic push(input logic [W-1:0] v);
    int n;
    n = 0;
    exp_valid = 1; exp_data = v;
    while (!exp_ready && n < 50) begin step(); n++; end
    total++;
    if (exp_ready !== 1'b1) begin
      bad++; $display("FAIL push_ready got=%0b want=1", exp_ready);
    end
    step();
    exp_valid = 0;
    model_q.push_back(v);
  endtask

  // Strobe one received value; the model predicts the error pulse from the queue head.
  task automatic ret(input logic [W-1:0] v);
    logic want;
    want = (model_q.size() == 0) || (model_q[0] != v);
    if (model_q.size() != 0) void'(model_q.pop_front());
    if (want) model_errs++;
    output_valid = 1; y = v;
    step();
    output_valid = 0;
    total++;
    if (error !== want) begin
      bad++; $display("FAIL ret_error got=%0b want=%0b y=%0h", error, want, v);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      total++;
      if (error !== 1'b0) begin
        bad++; $display("FAIL idle_error got=%0b want=0", error);
      end
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin step(); n++; end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL wait_done got=%0b want=1 after %0d cycles", done, n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({exp_ready, error, error_count, checked_count, done, pass, timeout} !== {1'b1, 1'b0, 16'd0, 16'd0, 3'b000}) begin
      bad++; $display("FAIL reset_main got=%b %b %0d %0d %b%b%b want=1 0 0 0 000",
                      exp_ready, error, error_count, checked_count, done, pass, timeout);
    end
    total++;
    if ({exp_ready_f, error_f, error_count_f, checked_count_f, done_f, pass_f, timeout_f} !== {1'b1, 1'b0, 16'd0, 16'd0, 3'b000}) begin
      bad++; $display("FAIL reset_full_inst got=%b %b %0d %0d %b%b%b want=1 0 0 0 000",
                      exp_ready_f, error_f, error_count_f, checked_count_f, done_f, pass_f, timeout_f);
    end
  endtask

  task automatic test_match();
    logic [W-1:0] v [4];
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) v[i] = rand_val();
    for (int i = 0; i < 4; i++) begin push(v[i]); idle_gap($urandom_range(1, 0)); end
    for (int i = 0; i < 4; i++) begin ret(v[i]); idle_gap($urandom_range(2, 0)); end
    wait_done(10, n);
    step();
    total++;
    if ({pass, timeout, error_count, checked_count} !== {1'b1, 1'b0, 16'd0, 16'd4}) begin
      bad++; $display("FAIL match_final got=pass%b to%b err%0d chk%0d want=pass1 to0 err0 chk4",
                      pass, timeout, error_count, checked_count);
    end
    // A strobe after completion is unexpected and must be flagged.
    output_valid = 1; y = v[0];
    step();
    output_valid = 0;
    total++;
    if ({error, error_count, checked_count} !== {1'b1, 16'd1, 16'd4}) begin
      bad++; $display("FAIL done_strobe got=e%b err%0d chk%0d want=e1 err1 chk4", error, error_count, checked_count);
    end
    step();
    total++;
    if ({error, pass, done} !== 3'b001) begin
      bad++; $display("FAIL done_strobe_after got=e%b p%b d%b want=e0 p0 d1", error, pass, done);
    end
  endtask

  task automatic test_mismatch();
    logic [W-1:0] v [4];
    int k, n;
    apply_reset();
    k = $urandom_range(3, 0);
    for (int i = 0; i < 4; i++) v[i] = rand_val();
    for (int i = 0; i < 4; i++) push(v[i]);
    for (int i = 0; i < 4; i++) ret((i == k) ? corrupt(v[i]) : v[i]);
    wait_done(10, n);
    step();
    total++;
    if ({error_count, pass, checked_count} !== {16'd1, 1'b0, 16'd4}) begin
      bad++; $display("FAIL mismatch_final got=err%0d pass%b chk%0d want=err1 pass0 chk4",
                      error_count, pass, checked_count);
    end
  endtask

  task automatic test_full();
    logic [W-1:0] v [5];
    apply_reset();
    for (int i = 0; i < 5; i++) v[i] = rand_val();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (exp_ready_f !== 1'b1) begin
        bad++; $display("FAIL full_fill_ready got=%0b want=1 entry=%0d", exp_ready_f, i);
      end
      exp_valid_f = 1; exp_data_f = v[i];
      step();
    end
    exp_data_f = v[4];
    total++;
    if (exp_ready_f !== 1'b0) begin
      bad++; $display("FAIL full_ready got=%0b want=0", exp_ready_f);
    end
    // Pop and push in the same cycle on a full queue: pop wins, push held.
    output_valid_f = 1; y_f = v[0];
    step();
    output_valid_f = 0;
    total++;
    if ({error_f, exp_ready_f} !== 2'b01) begin
      bad++; $display("FAIL full_pop_push got=err%b rdy%b want=err0 rdy1", error_f, exp_ready_f);
    end
    step();
    exp_valid_f = 0;
    total++;
    if (exp_ready_f !== 1'b0) begin
      bad++; $display("FAIL full_refill_ready got=%0b want=0", exp_ready_f);
    end
    for (int i = 1; i < 5; i++) begin
      output_valid_f = 1; y_f = v[i];
      step();
      output_valid_f = 0;
      total++;
      if (error_f !== 1'b0) begin
        bad++; $display("FAIL full_drain_error got=%0b want=0 idx=%0d", error_f, i);
      end
    end
    total++;
    if ({checked_count_f, error_count_f} !== {16'd5, 16'd0}) begin
      bad++; $display("FAIL full_counts got=chk%0d err%0d want=chk5 err0", checked_count_f, error_count_f);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    exp_valid = 1; exp_data = 35'd5;
    output_valid = 1; y = 35'd5;
    step();
    exp_valid = 0; output_valid = 0;
    model_q.push_back(35'd5);
    model_errs++;
    total++;
    if ({error, error_count, checked_count} !== {1'b1, 16'd1, 16'd0}) begin
      bad++; $display("FAIL underflow got=e%b err%0d chk%0d want=e1 err1 chk0", error, error_count, checked_count);
    end
    ret(35'd5);
    total++;
    if ({error_count, checked_count} !== {16'd1, 16'd1}) begin
      bad++; $display("FAIL underflow_head got=err%0d chk%0d want=err1 chk1", error_count, checked_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) push(rand_val());
    ret(model_q[0]);
    ret(model_q[0]);
    wait_done(400, n);
    total++;
    if (n < 256 || n > 258 || timeout !== 1'b1) begin
      bad++; $display("FAIL timeout got=cycles%0d to%b want=cycles256..258 to1", n, timeout);
    end
    step();
    total++;
    if ({pass, error_count, checked_count} !== {1'b0, 16'd0, 16'd2}) begin
      bad++; $display("FAIL timeout_final got=pass%b err%0d chk%0d want=pass0 err0 chk2", pass, error_count, checked_count);
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] v;
    apply_reset();
    for (int i = 0; i < 3; i++) push(rand_val());
    ret(corrupt(model_q[0]));
    push(rand_val());
    // Three entries queued, one error recorded, run in DRAIN.
    #3 resetn = 0;
    #1;
    total++;
    if ({error, error_count, checked_count, done, pass, timeout} !== {1'b0, 16'd0, 16'd0, 3'b000}) begin
      bad++; $display("FAIL midrun_reset got=e%b err%0d chk%0d %b%b%b want=e0 err0 chk0 000",
                      error, error_count, checked_count, done, pass, timeout);
    end
    step();
    resetn = 1;
    step();
    model_q.delete();
    model_errs = 0;
    total++;
    if (exp_ready !== 1'b1) begin
      bad++; $display("FAIL midrun_ready got=%0b want=1", exp_ready);
    end
    v = rand_val();
    push(v);
    ret(v);
    total++;
    if ({error_count, checked_count} !== {16'd0, 16'd1}) begin
      bad++; $display("FAIL midrun_fresh got=err%0d chk%0d want=err0 chk1", error_count, checked_count);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++) begin
      int pushed, returned, n;
      logic [W-1:0] v;
      apply_reset();
      pushed = 0; returned = 0;
      while (pushed < 4 || returned < 4) begin
        if (pushed < 4 && (model_q.size() == 0 || $urandom_range(1, 0) == 1)) begin
          push(rand_val());
          pushed++;
        end else begin
          v = model_q[0];
          ret(($urandom_range(2, 0) == 0) ? corrupt(v) : v);
          returned++;
        end
        idle_gap($urandom_range(1, 0));
      end
      wait_done(10, n);
      step();
      total++;
      if ({error_count, checked_count, pass} !== {16'(model_errs), 16'd4, (model_errs == 0)}) begin
        bad++; $display("FAIL random_run%0d got=err%0d chk%0d pass%b want=err%0d chk4 pass%b",
                        r, error_count, checked_count, pass, model_errs, (model_errs == 0));
      end
    end
  endtask

  initial begin
    resetn = 0;
    test_reset();
    test_match();
    test_mismatch();
    test_full();
    test_underflow();
    test_timeout();
    test_reset_midrun();
    test_random_runs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_response_checker.md
FIR_RESPONSE_CHECKER -- requirements
Module: fir_response_checker

Interface
REQ-001 Parameter OUTPUT_WIDTH, default 35: width of expected and received FIR outputs (2*16+clog2(8)).
REQ-002 Parameter FIFO_DEPTH, default 8, power of two: expected-value queue depth.
REQ-003 Parameter NUM_VECTORS, default 64: number of expected results per run.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: maximum idle cycles in DRAIN before timeout.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 resetn  input  1  reset, asynchronous and active-low.
REQ-007 exp_valid  input  1  expected-value push request from stimulus side.
REQ-008 exp_data  input  OUTPUT_WIDTH  expected filter output.
REQ-009 exp_ready  output  1  queue can accept a push this cycle.
REQ-010 output_valid  input  1  filter output strobe from DUT.
REQ-011 y  input  OUTPUT_WIDTH  received filter output.
REQ-012 error  output  1  registered one-cycle mismatch/underflow pulse.
REQ-013 error_count  output  16  saturating error total.
REQ-014 checked_count  output  16  number of output_valid strobes accepted.
REQ-015 done  output  1  run complete (sticky).
REQ-016 pass  output  1  done with zero errors and no timeout.
REQ-017 timeout  output  1  sticky DRAIN-timeout flag.

Function
REQ-018 Push occurs when exp_valid && exp_ready; exp_ready SHALL equal !full, derived from registered occupancy.
REQ-019 Pop occurs when output_valid && !empty; popped entry compared to y in the same cycle, result registered.
REQ-020 error SHALL assert the cycle after output_valid if y != head entry, or if queue was empty (underflow); no push-to-pop bypass, so push and output_valid in the same cycle on an empty queue is an underflow.
REQ-021 Full queue with simultaneous pop: pop proceeds, push blocked (exp_ready low that cycle); occupancy decrements by one.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-023 error_count increments on each error pulse, saturating at 16'hFFFF.
REQ-024 checked_count increments on every output_valid in RUN or DRAIN, saturating at 16'hFFFF.
REQ-025 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on first push.
REQ-026 RUN->DRAIN when push count reaches NUM_VECTORS; further exp_valid ignored (exp_ready low in DRAIN and DONE).
REQ-027 DRAIN->DONE when checked_count == NUM_VECTORS, or when idle counter reaches TIMEOUT_CYCLES (sets timeout).
REQ-028 Idle counter clears on each output_valid and on DRAIN entry; runs only in DRAIN.
REQ-029 output_valid in IDLE or DONE SHALL count as an error (unexpected output).
REQ-030 pass = done && (error_count == 0) && !timeout, registered.

Reset
REQ-031 On resetn low: FSM IDLE, queue empty, all counters zero, error/done/pass/timeout 0, exp_ready 1 after release.
REQ-032 Reset asserted mid-run SHALL discard queue contents and counts immediately; no partial state survives.

Structure
REQ-033 State encoding localparams and default widths SHALL live in shared package fir_filter_pkg.
REQ-034 Queue SHALL be sub-module fir_check_fifo (synchronous FIFO, registered full/empty, occupancy output).
REQ-035 No combinational path from y or output_valid to any output.

Verification
REQ-036 NUM_VECTORS=4: push 10,20,30,40; return y 10,20,30,40 -> error never high, checked_count=4, done=1, pass=1.
REQ-037 Push 10,20,30,40; return 10,21,30,40 -> single error pulse one cycle after second strobe, error_count=1, pass=0.
REQ-038 FIFO_DEPTH=4: push 4 values without pops -> exp_ready 0; pop and push same cycle -> pop accepted, push held, occupancy 3.
REQ-039 output_valid with empty queue, concurrent push of 5 -> error pulse, 5 retained as head entry.
REQ-040 Push 4, return 2, stall -> timeout=1, done=1 after 256 idle cycles, pass=0.
REQ-041 Drop resetn mid-run with 3 entries queued -> all outputs zero next edge, queue empty, state IDLE.
